// File: rtl/axi_sched_pkg.sv
// Shared types and helpers for the AXI write-path scheduler.
// Holds the FSM state enum, default widths and the round-robin pick function.
package axi_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } sched_state_e;

  localparam int unsigned M_WIDTH_DEF   = 2;
  localparam int unsigned M_ID_DEF      = 2;
  localparam int unsigned MAX_OUT_DEF   = 4;
  localparam int unsigned WEIGHT_W_DEF  = 4;
  localparam int unsigned TIMEOUT_W_DEF = 8;

  localparam int unsigned NM_DEF  = 2 ** M_WIDTH_DEF;
  localparam int unsigned IDW_DEF = M_WIDTH_DEF + M_ID_DEF;
  localparam int unsigned CW_DEF  = $clog2(MAX_OUT_DEF) + 1;

  // Widest master vector the pick function handles (M_WIDTH <= 4).
  localparam int unsigned RR_MAX = 16;
  localparam int unsigned RR_IW  = $clog2(RR_MAX);

  function automatic int unsigned id_w(
    input int unsigned mw,
    input int unsigned mi
  );
    return mw + mi;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned mo);
    return $clog2(mo) + 1;
  endfunction

  // First requester strictly after ptr, wrapping modulo nm.
  // Scanning from the far end down leaves the nearest one as the result.
  function automatic int rr_first(
    input logic [RR_MAX-1:0] req,
    input int                ptr,
    input int                nm
  );
    int               win;
    int               pos;
    logic [RR_IW-1:0] idx;
    win = ptr;
    for (int k = RR_MAX; k >= 1; k--) begin
      if (k <= nm) begin
        pos = (ptr + k) & (nm - 1);
        idx = RR_IW'(pos);
        if (req[idx]) win = pos;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/sched_idx_fifo.sv
// Synchronous FIFO of master indices, kept in AW grant order.
// Ports: clk_i/rst_ni, push_i+data_i, pop_i, head_o, full_o, empty_o.
module sched_idx_fifo #(
  parameter int unsigned W     = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [AW-1:0]           wr_q;
  logic [AW-1:0]           rd_q;
  logic [AW:0]             cnt_q;
  logic                    push_ok;
  logic                    pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign pop_ok  = pop_i & ~empty_o;
  // A pop frees the head slot in the same edge, so full+pop may push.
  assign push_ok = push_i & (~full_o | pop_ok);
  assign head_o  = empty_o ? '0 : mem_q[rd_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop_ok) rd_q <= rd_q + AW'(1);
      unique case (1'b1)
        push_ok & ~pop_ok: cnt_q <= cnt_q + (AW+1)'(1);
        pop_ok & ~push_ok: cnt_q <= cnt_q - (AW+1)'(1);
        default:           cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/axi_wr_sched_arbiter.sv
// Write-path scheduler: weighted RR on AW, W routing FIFO, B route decode.
// Optional watchdog on a stuck grant: define AXI_WR_SCHED_TIMEOUT_EN.
module axi_wr_sched_arbiter
  import axi_sched_pkg::*;
#(
  parameter int unsigned M_WIDTH         = M_WIDTH_DEF,
  parameter int unsigned M_ID            = M_ID_DEF,
  parameter int unsigned MAX_OUTSTANDING = MAX_OUT_DEF,
  parameter int unsigned WEIGHT_W        = WEIGHT_W_DEF,
  parameter int unsigned TIMEOUT_W       = TIMEOUT_W_DEF,
  localparam int unsigned NM  = 2 ** M_WIDTH,
  localparam int unsigned IDW = id_w(M_WIDTH, M_ID),
  localparam int unsigned CW  = cnt_w(MAX_OUTSTANDING)
) (
  input  logic                         BUS_CLK,
  input  logic                         BUS_RSTN,
  input  logic [NM-1:0]                MASTER_WR_ADDR_VALID,
  input  logic [NM-1:0][WEIGHT_W-1:0]  WEIGHT,
  input  logic                         BUS_WR_ADDR_VALID,
  input  logic                         BUS_WR_ADDR_READY,
  input  logic                         BUS_WR_DATA_VALID,
  input  logic                         BUS_WR_DATA_READY,
  input  logic                         BUS_WR_DATA_LAST,
  input  logic [IDW-1:0]               BUS_WR_BACK_ID,
  input  logic                         BUS_WR_BACK_VALID,
  input  logic                         BUS_WR_BACK_READY,
  output logic [M_WIDTH-1:0]           wr_addr_master_sel,
  output logic                         wr_addr_grant,
  output logic [M_WIDTH-1:0]           wr_data_master_sel,
  output logic                         wr_data_sel_valid,
  output logic [M_WIDTH-1:0]           wr_resp_master_sel,
  output logic [CW-1:0]                outstanding_cnt,
  output logic                         wr_timeout_err
);

  sched_state_e         state_q;
  logic [M_WIDTH-1:0]   sel_q;
  logic [M_WIDTH-1:0]   ptr_q;
  logic                 grant_q;
  logic [WEIGHT_W-1:0]  credit_q;
  logic [CW-1:0]        cnt_q;

  logic                 aw_hs;
  logic                 w_last_hs;
  logic                 b_hs;
  logic                 cnt_dec;
  logic                 can_arb;
  logic                 keep;
  logic [M_WIDTH-1:0]   rr_win;
  logic [WEIGHT_W-1:0]  rr_wt;
  logic                 tmo_hit;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [M_WIDTH-1:0]   fifo_head;

  logic                 unused_bid;

  assign aw_hs     = BUS_WR_ADDR_VALID & BUS_WR_ADDR_READY & grant_q;
  assign w_last_hs = BUS_WR_DATA_VALID & BUS_WR_DATA_READY
                   & BUS_WR_DATA_LAST & ~fifo_empty;
  assign b_hs      = BUS_WR_BACK_VALID & BUS_WR_BACK_READY;
  assign cnt_dec   = b_hs & (cnt_q != '0);

  assign can_arb = (|MASTER_WR_ADDR_VALID)
                 && (cnt_q < CW'(MAX_OUTSTANDING))
                 && !fifo_full;
  assign keep    = (credit_q != '0) && MASTER_WR_ADDR_VALID[ptr_q];
  assign rr_win  = M_WIDTH'(rr_first(RR_MAX'(MASTER_WR_ADDR_VALID),
                                     int'(ptr_q), int'(NM)));
  // A zero weight still buys one grant.
  assign rr_wt   = (WEIGHT[rr_win] == '0) ? WEIGHT_W'(1)
                                          : WEIGHT[rr_win];

`ifdef AXI_WR_SCHED_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_q;
  logic                 err_q;

  assign tmo_hit        = (state_q == GRANT) && (&tmo_q) && !aw_hs;
  assign wr_timeout_err = err_q;

  // Every grant is preceded by an IDLE cycle, which zeroes the count.
  always_ff @(posedge BUS_CLK or negedge BUS_RSTN) begin
    if (!BUS_RSTN) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == IDLE)  tmo_q <= '0;
      else if (!(&tmo_q))   tmo_q <= tmo_q + TIMEOUT_W'(1);
      if (tmo_hit) err_q <= 1'b1;
    end
  end
`else
  logic [TIMEOUT_W-1:0] tmo_unused;

  assign tmo_unused     = '0;
  assign tmo_hit        = 1'b0;
  assign wr_timeout_err = 1'b0;
`endif

  always_ff @(posedge BUS_CLK or negedge BUS_RSTN) begin
    if (!BUS_RSTN) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      ptr_q    <= M_WIDTH'(NM - 1);
      grant_q  <= 1'b0;
      credit_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (can_arb) begin
            if (keep) begin
              sel_q <= ptr_q;
            end else begin
              sel_q    <= rr_win;
              ptr_q    <= rr_win;
              credit_q <= rr_wt;
            end
            grant_q <= 1'b1;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (aw_hs) begin
            grant_q  <= 1'b0;
            credit_q <= credit_q - WEIGHT_W'(1);
            state_q  <= IDLE;
          end else if (tmo_hit) begin
            grant_q  <= 1'b0;
            credit_q <= '0;
            ptr_q    <= ptr_q + M_WIDTH'(1);
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RSTN) begin
    if (!BUS_RSTN) begin
      cnt_q <= '0;
    end else begin
      unique case (1'b1)
        aw_hs & ~cnt_dec: cnt_q <= cnt_q + CW'(1);
        cnt_dec & ~aw_hs: cnt_q <= cnt_q - CW'(1);
        default:          cnt_q <= cnt_q;
      endcase
    end
  end

  sched_idx_fifo #(
    .W     (M_WIDTH),
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk_i   (BUS_CLK),
    .rst_ni  (BUS_RSTN),
    .push_i  (aw_hs),
    .data_i  (sel_q),
    .pop_i   (w_last_hs),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign unused_bid = ^BUS_WR_BACK_ID[M_ID-1:0];

  assign wr_addr_master_sel = sel_q;
  assign wr_addr_grant      = grant_q;
  assign wr_data_master_sel = fifo_head;
  assign wr_data_sel_valid  = ~fifo_empty;
  assign wr_resp_master_sel = BUS_WR_BACK_ID[IDW-1:M_ID];
  assign outstanding_cnt    = cnt_q;

endmodule

// File: tb/tb_axi_wr_sched_arbiter.sv
// Self-checking bench for axi_wr_sched_arbiter.
// Directed scenarios plus a random run against a transaction-level model.
module tb_axi_wr_sched_arbiter;

  localparam int NM  = 4;
  localparam int MO  = 4;
  localparam int WW  = 4;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic [NM-1:0]         mvalid;
  logic [NM-1:0][WW-1:0] weight;
  logic                  awready;
  logic                  wv, wr, wl;
  logic                  bv, br;
  logic [3:0]            bid;
  logic                  bus_awv;

  logic [1:0] aw_sel, w_sel, r_sel;
  logic       grant, wsv, terr;
  logic [2:0] cnt;

  always #5 clk = ~clk;

  // The bench plays the switch: muxed AWVALID follows the granted master.
  assign bus_awv = grant & mvalid[aw_sel];

  axi_wr_sched_arbiter #(
    .M_WIDTH(2), .M_ID(2), .MAX_OUTSTANDING(MO),
    .WEIGHT_W(WW), .TIMEOUT_W(8)
  ) dut (
    .BUS_CLK              (clk),
    .BUS_RSTN             (rstn),
    .MASTER_WR_ADDR_VALID (mvalid),
    .WEIGHT               (weight),
    .BUS_WR_ADDR_VALID    (bus_awv),
    .BUS_WR_ADDR_READY    (awready),
    .BUS_WR_DATA_VALID    (wv),
    .BUS_WR_DATA_READY    (wr),
    .BUS_WR_DATA_LAST     (wl),
    .BUS_WR_BACK_ID       (bid),
    .BUS_WR_BACK_VALID    (bv),
    .BUS_WR_BACK_READY    (br),
    .wr_addr_master_sel   (aw_sel),
    .wr_addr_grant        (grant),
    .wr_data_master_sel   (w_sel),
    .wr_data_sel_valid    (wsv),
    .wr_resp_master_sel   (r_sel),
    .outstanding_cnt      (cnt),
    .wr_timeout_err       (terr)
  );

  int vec;
  int errs;

  // reference model state
  int m_ptr, m_credit, m_sel, m_cnt, m_tmo;
  bit m_grant, m_err;
  int m_q[$];

  // AW handshake seen on the DUT side of the last edge
  bit d_aw;
  int d_aw_m;

  task automatic model_reset();
    m_ptr = NM - 1; m_credit = 0; m_sel = 0; m_cnt = 0; m_tmo = 0;
    m_grant = 0; m_err = 0;
    m_q.delete();
  endtask

  task automatic drive_idle();
    mvalid = '0; awready = 0; wv = 0; wr = 0; wl = 0;
    bv = 0; br = 0; bid = '0;
    for (int i = 0; i < NM; i++) weight[i] = WW'(1);
  endtask

  task automatic do_reset();
    drive_idle();
    rstn = 0;
    #20;
    rstn = 1;
    model_reset();
  endtask

  // Advance model and DUT across one rising edge.
  task automatic tick();
    bit aw, pop, b;
    int qs, cpre, nx;
    #1;
    d_aw   = bus_awv && awready;
    d_aw_m = int'(aw_sel);
    qs   = m_q.size();
    cpre = m_cnt;
    aw   = m_grant && mvalid[m_sel] && awready;
    pop  = wv && wr && wl && (qs > 0);
    b    = bv && br;
    m_cnt = m_cnt + (aw ? 1 : 0) - ((b && cpre > 0) ? 1 : 0);
    if (pop) void'(m_q.pop_front());
    if (aw)  m_q.push_back(m_sel);
    if (!m_grant) begin
      if (mvalid != 0 && cpre < MO && qs < MO) begin
        if (m_credit > 0 && mvalid[m_ptr]) begin
          m_sel = m_ptr;
        end else begin
          nx = m_ptr;
          for (int k = 1; k <= NM; k++) begin
            nx = (m_ptr + k) % NM;
            if (mvalid[nx]) break;
          end
          m_ptr = nx;
          m_sel = nx;
          m_credit = (weight[nx] == 0) ? 1 : int'(weight[nx]);
        end
        m_grant = 1;
        m_tmo = 0;
      end
    end else if (aw) begin
      m_grant = 0;
      m_credit--;
    end
`ifdef AXI_WR_SCHED_TIMEOUT_EN
    else if (m_tmo == 255) begin
      m_grant = 0; m_credit = 0; m_err = 1;
      m_ptr = (m_ptr + 1) % NM;
    end else m_tmo++;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_idle();
    rstn = 0;
    #12;
    vec++;
    if (grant !== 1'b0) begin errs++;
      $display("FAIL reset_grant got %b want 0", grant); end
    vec++;
    if (aw_sel !== 2'd0) begin errs++;
      $display("FAIL reset_aw_sel got %0d want 0", aw_sel); end
    vec++;
    if (wsv !== 1'b0 || w_sel !== 2'd0) begin errs++;
      $display("FAIL reset_w got %b/%0d want 0/0", wsv, w_sel); end
    vec++;
    if (cnt !== 3'd0) begin errs++;
      $display("FAIL reset_cnt got %0d want 0", cnt); end
    vec++;
    if (terr !== 1'b0 || r_sel !== 2'd0) begin errs++;
      $display("FAIL reset_misc got %b/%0d want 0/0", terr, r_sel); end
    rstn = 1;
    model_reset();
  endtask

  // Run a continuously-requesting pattern and compare the grant order.
  task automatic run_order(input logic [NM-1:0] req, input int n,
                           output int got[$], output int at[$]);
    got.delete(); at.delete();
    mvalid = req; awready = 1; wv = 1; wr = 1; wl = 1; br = 1;
    for (int i = 0; i < 60 && got.size() < n; i++) begin
      bv = (m_cnt > 0);
      bid = 4'(m_q.size() > 0 ? m_q[0] << 2 : 0);
      tick();
      if (d_aw) begin got.push_back(d_aw_m); at.push_back(i); end
    end
    mvalid = '0; bv = 0;
  endtask

  task automatic test_alternate();
    int got[$], at[$];
    int exp_o[4] = '{0, 2, 0, 2};
    do_reset();
    run_order(4'b0101, 4, got, at);
    vec++;
    if (got.size() != 4) begin errs++;
      $display("FAIL alt_count got %0d want 4", got.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        vec++;
        if (got[i] != exp_o[i]) begin errs++;
          $display("FAIL alt_order[%0d] got %0d want %0d",
                   i, got[i], exp_o[i]); end
      end
      for (int i = 1; i < 4; i++) begin
        vec++;
        if (at[i] - at[i-1] != 2) begin errs++;
          $display("FAIL alt_gap[%0d] got %0d want 2",
                   i, at[i] - at[i-1]); end
      end
    end
  endtask

  task automatic test_weight();
    int got[$], at[$];
    int exp_o[8] = '{1, 1, 1, 3, 1, 1, 1, 3};
    do_reset();
    weight[1] = 4'd3;
    run_order(4'b1010, 8, got, at);
    vec++;
    if (got.size() != 8) begin errs++;
      $display("FAIL wt_count got %0d want 8", got.size()); end
    else begin
      for (int i = 0; i < 8; i++) begin
        vec++;
        if (got[i] != exp_o[i]) begin errs++;
          $display("FAIL wt_order[%0d] got %0d want %0d",
                   i, got[i], exp_o[i]); end
      end
    end
  endtask

  task automatic test_outstanding();
    int n;
    do_reset();
    mvalid = 4'b0001; awready = 1; wv = 1; wr = 1; wl = 1;
    n = 0;
    for (int i = 0; i < 30 && n < 4; i++) begin
      tick();
      if (d_aw) n++;
    end
    vec++;
    if (n != 4) begin errs++;
      $display("FAIL out_fill got %0d AWs want 4", n); end
    for (int i = 0; i < 6; i++) tick();
    vec++;
    if (cnt !== 3'd4 || grant !== 1'b0) begin errs++;
      $display("FAIL out_full got cnt=%0d grant=%b want 4/0", cnt, grant);
    end
    bv = 1; br = 1;
    tick();
    bv = 0;
    vec++;
    if (cnt !== 3'd3 || grant !== 1'b0) begin errs++;
      $display("FAIL out_b got cnt=%0d grant=%b want 3/0", cnt, grant);
    end
    tick();
    vec++;
    if (grant !== 1'b1 || aw_sel !== 2'd0) begin errs++;
      $display("FAIL out_regrant got %b/%0d want 1/0", grant, aw_sel);
    end
    tick();
    vec++;
    if (cnt !== 3'd4) begin errs++;
      $display("FAIL out_refill got %0d want 4", cnt); end
    mvalid = '0;
  endtask

  task automatic test_wdata_order();
    bit seen;
    do_reset();
    awready = 1;
    mvalid = 4'b1000;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin tick(); seen = d_aw; end
    mvalid = 4'b0001;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin tick(); seen = d_aw; end
    mvalid = '0;
    vec++;
    if (!seen) begin errs++; $display("FAIL wd_aw got none want 1"); end
    for (int i = 0; i < 8; i++) begin
      wv = (i == 3); wr = 0; wl = 1;
      tick();
      vec++;
      if (w_sel !== 2'd3 || wsv !== 1'b1) begin errs++;
        $display("FAIL wd_hold[%0d] got %0d/%b want 3/1", i, w_sel, wsv);
      end
    end
    wv = 1; wr = 1; wl = 1;
    tick();
    wv = 0;
    vec++;
    if (w_sel !== 2'd0 || wsv !== 1'b1) begin errs++;
      $display("FAIL wd_pop got %0d/%b want 0/1", w_sel, wsv); end
    mvalid = 4'b0100;
    tick();
    vec++;
    if (grant !== 1'b1 || aw_sel !== 2'd2) begin errs++;
      $display("FAIL wd_g2 got %b/%0d want 1/2", grant, aw_sel); end
    wv = 1; wr = 1; wl = 1;
    tick();
    mvalid = '0;
    vec++;
    if (w_sel !== 2'd2 || wsv !== 1'b1) begin errs++;
      $display("FAIL wd_pushpop got %0d/%b want 2/1", w_sel, wsv); end
    tick();
    wv = 0;
    vec++;
    if (wsv !== 1'b0) begin errs++;
      $display("FAIL wd_empty got %b want 0", wsv); end
  endtask

  task automatic test_bresp();
    do_reset();
    bid = 4'b1001; bv = 1; br = 0;
    #1;
    vec++;
    if (r_sel !== 2'd2) begin errs++;
      $display("FAIL bid_10xx got %0d want 2", r_sel); end
    bid = 4'b0111;
    #1;
    vec++;
    if (r_sel !== 2'd1) begin errs++;
      $display("FAIL bid_01xx got %0d want 1", r_sel); end
    br = 1;
    tick();
    vec++;
    if (cnt !== 3'd0) begin errs++;
      $display("FAIL b_underflow got %0d want 0", cnt); end
    bv = 0;
    mvalid = 4'b0001; awready = 1; wv = 1; wr = 1; wl = 1;
    tick(); tick();
    vec++;
    if (cnt !== 3'd1) begin errs++;
      $display("FAIL b_one got %0d want 1", cnt); end
    tick();
    vec++;
    if (grant !== 1'b1) begin errs++;
      $display("FAIL b_grant got %b want 1", grant); end
    bv = 1; br = 1;
    tick();
    bv = 0; mvalid = '0;
    vec++;
    if (cnt !== 3'd1) begin errs++;
      $display("FAIL aw_b_same got %0d want 1", cnt); end
  endtask

  task automatic test_stuck_grant();
    do_reset();
    mvalid = 4'b0010; awready = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      vec++;
      if (grant !== m_grant || terr !== m_err) begin errs++;
        $display("FAIL stuck[%0d] got %b/%b want %b/%b",
                 i, grant, terr, m_grant, m_err);
      end
    end
`ifdef AXI_WR_SCHED_TIMEOUT_EN
    vec++;
    if (terr !== 1'b1) begin errs++;
      $display("FAIL tmo_err got %b want 1", terr); end
`else
    vec++;
    if (grant !== 1'b1 || aw_sel !== 2'd1 || terr !== 1'b0) begin errs++;
      $display("FAIL hold got %b/%0d/%b want 1/1/0", grant, aw_sel, terr);
    end
`endif
    rstn = 0;
    #1;
    vec++;
    if (terr !== 1'b0 || grant !== 1'b0) begin errs++;
      $display("FAIL tmo_clear got %b/%b want 0/0", terr, grant); end
    rstn = 1;
    model_reset();
    mvalid = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    mvalid = 4'b0011; awready = 1;
    for (int i = 0; i < 6; i++) tick();
    awready = 0;
    tick(); tick();
    vec++;
    if (grant !== 1'b1 || cnt !== 3'(m_cnt) || m_cnt == 0) begin errs++;
      $display("FAIL ar_pre got %b/%0d want 1/%0d", grant, cnt, m_cnt);
    end
    #3;
    rstn = 0;
    #1;
    vec++;
    if (grant !== 1'b0 || aw_sel !== 2'd0 || cnt !== 3'd0 ||
        wsv !== 1'b0 || w_sel !== 2'd0 || terr !== 1'b0) begin errs++;
      $display("FAIL ar_clear got g=%b s=%0d c=%0d v=%b w=%0d e=%b want 0",
               grant, aw_sel, cnt, wsv, w_sel, terr);
    end
    #2;
    rstn = 1;
    model_reset();
    drive_idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < NM; i++) weight[i] = WW'($urandom_range(0, 3));
    for (int c = 0; c < 1500; c++) begin
      for (int m = 0; m < NM; m++)
        if (!mvalid[m] && $urandom_range(0, 3) == 0) mvalid[m] = 1;
      awready = ($urandom_range(0, 3) != 0);
      wv = $urandom_range(0, 1) == 1;
      wr = $urandom_range(0, 1) == 1;
      wl = $urandom_range(0, 2) == 0;
      bv = (m_cnt > 0) && ($urandom_range(0, 1) == 1);
      br = $urandom_range(0, 1) == 1;
      bid = 4'($urandom_range(0, 15));
      tick();
      if (d_aw && $urandom_range(0, 1) == 1) mvalid[d_aw_m] = 0;
      vec++;
      if (grant !== m_grant || (m_grant && aw_sel !== 2'(m_sel))) begin
        errs++;
        $display("FAIL rnd_aw[%0d] got %b/%0d want %b/%0d",
                 c, grant, aw_sel, m_grant, m_sel);
      end
      vec++;
      if (wsv !== (m_q.size() > 0) ||
          w_sel !== 2'(m_q.size() > 0 ? m_q[0] : 0)) begin
        errs++;
        $display("FAIL rnd_w[%0d] got %b/%0d want %b/%0d", c, wsv, w_sel,
                 m_q.size() > 0, m_q.size() > 0 ? m_q[0] : 0);
      end
      vec++;
      if (cnt !== 3'(m_cnt)) begin errs++;
        $display("FAIL rnd_cnt[%0d] got %0d want %0d", c, cnt, m_cnt); end
      vec++;
      if (r_sel !== bid[3:2] || terr !== m_err) begin errs++;
        $display("FAIL rnd_b[%0d] got %0d/%b want %0d/%b",
                 c, r_sel, terr, bid[3:2], m_err);
      end
    end
  endtask

  initial begin
    vec = 0;
    errs = 0;
    test_reset();
    test_alternate();
    test_weight();
    test_outstanding();
    test_wdata_order();
    test_bresp();
    test_stuck_grant();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
